// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants, state encoding and address helpers for the cache line-fill controller.
package cache_fill_ctrl_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int NUM_WORDS      = 64;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int CNT_W   = OFF_W + 1;
    localparam int ENT_W   = $clog2(NUM_WORDS);
    localparam int IDX_W   = ENT_W - OFF_W;
    localparam int OFF_LSB = 1;
    localparam int IDX_LSB = OFF_LSB + OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte address of the first word of the line containing addr.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:IDX_LSB], IDX_LSB'(0)};
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_dec.sv
// 6-bit index to 64-bit one-hot decoder with enable; all-zero when disabled.
module onehot_dec_6to64
    import cache_fill_ctrl_pkg::*;
(
    input  logic                 i_en,
    input  logic [ENT_W-1:0]     i_idx,
    output logic [NUM_WORDS-1:0] o_onehot
);

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_dec
        assign o_onehot[gi] = i_en && (i_idx == ENT_W'(gi));
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: fetches one line on a miss and writes it into the data array.
// Optional critical-word forwarding is built when FILL_EARLY_RESTART_EN is defined.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [ADDR_W-1:0]    miss_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 mem_valid,
    output logic                 data_write,
    output logic [NUM_WORDS-1:0] block_en_lo,
    output logic [NUM_WORDS-1:0] block_en_hi,
    output logic [DATA_W-1:0]    data_out,
    output logic                 tag_write,
    output logic                 stall
`ifdef FILL_EARLY_RESTART_EN
    ,
    output logic                 crit_valid,
    output logic [DATA_W-1:0]    crit_data
`endif
);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic [CNT_W-1:0]      r_ret_cnt;
    logic [ADDR_W-1:0]     r_base;
    logic [IDX_W-1:0]      r_line_idx;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_ret;
    logic                  w_last_ret;
    logic [ENT_W-1:0]      w_ent_idx;
    logic [NUM_WORDS-1:0]  w_onehot;
    logic                  w_unused;

    assign w_accept   = (r_state == ST_IDLE) && miss;
    assign w_issue    = (r_state == ST_FILL) && !r_issue_cnt[OFF_W];
    assign w_ret      = (r_state == ST_FILL) && mem_valid;
    assign w_last_ret = w_ret && (r_ret_cnt[OFF_W-1:0] == OFF_W'(WORDS_PER_LINE - 1));
    assign w_unused   = ^{miss_addr[IDX_LSB-1:0], r_ret_cnt[OFF_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (miss)       w_state_next = ST_FILL;
            ST_FILL: if (w_last_ret) w_state_next = ST_DONE;
            ST_DONE:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_base      <= '0;
            r_line_idx  <= '0;
        end else if (w_accept) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_base      <= line_base(miss_addr);
            r_line_idx  <= miss_addr[IDX_LSB +: IDX_W];
        end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (w_ret)   r_ret_cnt   <= r_ret_cnt + CNT_W'(1);
        end
    end

    // Stall in IDLE follows miss directly so the pipeline freezes in the acceptance cycle.
    always_comb begin
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        data_write = 1'b0;
        data_out   = '0;
        tag_write  = 1'b0;
        stall      = 1'b0;
        case (r_state)
            ST_IDLE: stall = miss & rst;
            ST_FILL: begin
                stall     = 1'b1;
                mem_rd_en = w_issue;
                if (w_issue) mem_addr = r_base + ADDR_W'({r_issue_cnt[OFF_W-1:0], 1'b0});
                data_write = mem_valid;
                if (mem_valid) data_out = mem_data;
            end
            ST_DONE: begin
                stall     = 1'b1;
                tag_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_ent_idx = {r_line_idx, r_ret_cnt[OFF_W-1:0]};

    onehot_dec_6to64 u_dec (
        .i_en     (data_write),
        .i_idx    (w_ent_idx),
        .o_onehot (w_onehot)
    );

    assign block_en_lo = w_onehot;
    assign block_en_hi = w_onehot;

`ifdef FILL_EARLY_RESTART_EN
    logic [OFF_W-1:0] r_crit_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crit_off <= '0;
        end else if (w_accept) begin
            r_crit_off <= miss_addr[OFF_LSB +: OFF_W];
        end
    end

    assign crit_valid = data_write && (r_ret_cnt[OFF_W-1:0] == r_crit_off);
    assign crit_data  = crit_valid ? mem_data : '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: table-driven fills, spurious-return vectors,
// a mid-fill reset sequence and randomized fills against a line-level reference model.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss = 1'b0;
    logic [15:0] miss_addr = 16'h0;
    logic [15:0] mem_data = 16'h0;
    logic        mem_valid = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        data_write;
    logic [63:0] block_en_lo;
    logic [63:0] block_en_hi;
    logic [15:0] data_out;
    logic        tag_write;
    logic        stall;
`ifdef FILL_EARLY_RESTART_EN
    logic        crit_valid;
    logic [15:0] crit_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cache_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .miss        (miss),
        .miss_addr   (miss_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .data_write  (data_write),
        .block_en_lo (block_en_lo),
        .block_en_hi (block_en_hi),
        .data_out    (data_out),
        .tag_write   (tag_write),
        .stall       (stall)
`ifdef FILL_EARLY_RESTART_EN
        ,
        .crit_valid  (crit_valid),
        .crit_data   (crit_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        exp_dw;
        logic        exp_stall;
        logic [63:0] exp_en;
    } idle_vec_t;

    typedef struct {
        logic [15:0] addr;
        int          lat;
        int          max_gap;
        bit          b2b;
        int          exp_stall;
    } fill_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".data_write"}, 64'(data_write), 64'd0);
        chk({tag, ".block_en_lo"}, block_en_lo, 64'd0);
        chk({tag, ".block_en_hi"}, block_en_hi, 64'd0);
        chk({tag, ".data_out"}, 64'(data_out), 64'd0);
        chk({tag, ".tag_write"}, 64'(tag_write), 64'd0);
        chk({tag, ".stall"}, 64'(stall), 64'd0);
`ifdef FILL_EARLY_RESTART_EN
        chk({tag, ".crit_valid"}, 64'(crit_valid), 64'd0);
`endif
    endtask

    // One IDLE cycle with miss low; optional stray mem_valid must be ignored.
    task automatic idle_cycle(input logic v);
        @(posedge clk); #1;
        miss      = 1'b0;
        mem_valid = v;
        mem_data  = 16'($urandom);
        @(negedge clk);
        chk_quiet("idle");
    endtask

    // Reference model of one line fill: requests on FILL cycles 1..8 at base+2k,
    // returns in order (latency lat, random gaps), write k targets entry line*8+k,
    // tag_write and stall in the cycle after the 8th return.
    task automatic do_fill(input logic [15:0] addr, input int lat, input int max_gap,
                           output int stall_cnt);
        logic [15:0] exp_base;
        logic [63:0] exp_en;
        logic        v;
        logic        exp_rd;
        logic [15:0] d;
        int          line;
        int          n_iss;
        int          n_ret;
        int          next_ok;
        int          tag_cyc;
        int          iss_cyc [8];
        bit          done;
        exp_base  = {addr[15:4], 4'h0};
        line      = int'(addr[6:4]);
        n_iss     = 0;
        n_ret     = 0;
        next_ok   = 0;
        tag_cyc   = -1;
        stall_cnt = 0;
        done      = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                miss      = 1'b1;
                miss_addr = addr;
            end else begin
                miss      = 1'($urandom);
                miss_addr = 16'($urandom);
            end
            v = (c > 0) && (n_ret < n_iss) && (tag_cyc < 0) &&
                (c >= iss_cyc[n_ret] + lat) && (c >= next_ok);
            d         = 16'($urandom);
            mem_valid = v;
            mem_data  = d;
            @(negedge clk);
            exp_rd = (c >= 1) && (c <= 8);
            chk("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd));
            if (exp_rd) chk("mem_addr", 64'(mem_addr), 64'(exp_base + 16'(2 * (c - 1))));
            chk("data_write", 64'(data_write), 64'(v));
            exp_en = v ? (64'd1 << (line * 8 + n_ret)) : 64'd0;
            chk("block_en_lo", block_en_lo, exp_en);
            chk("block_en_hi", block_en_hi, exp_en);
            if (v) chk("data_out", 64'(data_out), 64'(d));
`ifdef FILL_EARLY_RESTART_EN
            chk("crit_valid", 64'(crit_valid), 64'(v && (n_ret == int'(addr[3:1]))));
            if (v && (n_ret == int'(addr[3:1]))) chk("crit_data", 64'(crit_data), 64'(d));
`endif
            chk("tag_write", 64'(tag_write), 64'((tag_cyc >= 0) && (c == tag_cyc)));
            chk("stall", 64'(stall), 64'd1);
            if (stall) stall_cnt++;
            if ((tag_cyc >= 0) && (c == tag_cyc)) done = 1'b1;
            if (v) begin
                n_ret++;
                next_ok = c + 1 + int'($urandom_range(0, max_gap));
                if (n_ret == 8) tag_cyc = c + 1;
            end
            if (exp_rd) begin
                iss_cyc[n_iss] = c;
                n_iss++;
            end
        end
        chk("fill_completed", 64'(done), 64'd1);
        $display("fill addr=%h lat=%0d gap<=%0d writes=%0d stall_cycles=%0d",
                 addr, lat, max_gap, n_ret, stall_cnt);
    endtask

    idle_vec_t idle_tbl [6];
    fill_vec_t fill_tbl [6];

    initial begin
        int          sc;
        logic [15:0] a;
        bit          b2b;

        idle_tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 64'd0};
        idle_tbl[1] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 64'd0};
        idle_tbl[2] = '{1'b1, 16'h1234, 1'b0, 1'b0, 64'd0};
        idle_tbl[3] = '{1'b0, 16'hA5A5, 1'b0, 1'b0, 64'd0};
        idle_tbl[4] = '{1'b1, 16'h8001, 1'b0, 1'b0, 64'd0};
        idle_tbl[5] = '{1'b1, 16'h7FFE, 1'b0, 1'b0, 64'd0};

        fill_tbl[0] = '{16'h0034, 3, 0, 1'b0, 13};
        fill_tbl[1] = '{16'h1256, 2, 3, 1'b0, 0};
        fill_tbl[2] = '{16'hABC0, 1, 0, 1'b1, 11};
        fill_tbl[3] = '{16'h0070, 5, 2, 1'b0, 0};
        fill_tbl[4] = '{16'h0036, 1, 3, 1'b0, 0};
        fill_tbl[5] = '{16'hFFFE, 4, 1, 1'b0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        $display("reset state checked");
        rst = 1'b1;

        // Spurious returns in IDLE
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            miss      = 1'b0;
            mem_valid = idle_tbl[i].valid;
            mem_data  = idle_tbl[i].data;
            @(negedge clk);
            chk("spur.data_write", 64'(data_write), 64'(idle_tbl[i].exp_dw));
            chk("spur.stall", 64'(stall), 64'(idle_tbl[i].exp_stall));
            chk("spur.block_en_lo", block_en_lo, idle_tbl[i].exp_en);
            chk("spur.block_en_hi", block_en_hi, idle_tbl[i].exp_en);
            $display("spurious vec %0d valid=%0d data=%h", i, idle_tbl[i].valid, idle_tbl[i].data);
        end

        // Directed fills, including a back-to-back pair
        for (int i = 0; i < 6; i++) begin
            do_fill(fill_tbl[i].addr, fill_tbl[i].lat, fill_tbl[i].max_gap, sc);
            if (fill_tbl[i].exp_stall != 0) chk("stall_cycles", 64'(sc), 64'(fill_tbl[i].exp_stall));
            if (!fill_tbl[i].b2b) idle_cycle(1'b1);
        end

        // Reset mid-fill after three returned words
        @(posedge clk); #1;
        miss = 1'b1; miss_addr = 16'h0050; mem_valid = 1'b0;
        @(posedge clk); #1;
        miss = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_valid = 1'b1;
            mem_data  = 16'h4000 + 16'(k);
            @(negedge clk);
            chk("rst_pre.data_write", 64'(data_write), 64'd1);
            chk("rst_pre.block_en_lo", block_en_lo, 64'd1 << (40 + k));
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            miss      = 1'b0;
            mem_valid = 1'b1;
            mem_data  = 16'($urandom);
            @(negedge clk);
            chk_quiet("rst_late");
        end
        mem_valid = 1'b0;
        $display("mid-fill reset sequence done");

        // Randomized fills
        b2b = 1'b0;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            do_fill(a, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), sc);
            b2b = 1'($urandom);
            if (!b2b) idle_cycle(1'($urandom));
        end
        idle_cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
